dm_resp: RTL and testbench

//  Data-memory responder: the slave end of the CPU load/store port. Accepts one

---
 rtl/dm_pkg.sv | 22 ++
 rtl/dm_word_ram.sv | 38 +++
 rtl/dm_resp.sv | 151 +++++++++++++++
 tb/tb_dm_resp.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: FSM state encodings,
// default geometry and the address-legality helper.
package dm_pkg;

  localparam int DM_ADDR_W_DEF = 10;
  localparam int DM_WORD_W     = 32;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dm_state_e;

  // A request is illegal when it is not word aligned or when it points past
  // the last storage word (any byte-address bit above the word index set).
  function automatic logic dm_addr_err(input logic [31:0] addr, input int unsigned aw);
    logic [31:0] hi_s;
    hi_s = addr >> (aw + 32'd2);
    return (addr[1:0] != 2'b00) || (hi_s != 32'd0);
  endfunction

endpackage

// File: rtl/dm_word_ram.sv
// Word storage for dm_resp: 2**ADDR_W x 32 bits, cleared by the asynchronous
// reset, written synchronously with per-byte enables, read combinationally.
module dm_word_ram
  import dm_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [DM_WORD_W-1:0] wdata_i,
  input  logic [3:0]           be_i,
  output logic [DM_WORD_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DM_WORD_W-1:0] mem_q [DEPTH];

  // Storage array: full clear on reset, byte-masked write otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dm_resp.sv
// Data-memory responder: slave end of the CPU load/store port. One word
// request per handshake, a fixed number of wait states, then a response held
// until the initiator takes it.
// Optional feature macro: DM_BYTE_STROBE_EN adds the req_be byte-strobe port;
// without it every store writes the full word.
module dm_resp
  import dm_pkg::*;
#(
  parameter int ADDR_W      = DM_ADDR_W_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
`ifdef DM_BYTE_STROBE_EN
  input  logic [3:0]           req_be,
`endif
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err
);

  dm_state_e            state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    idx_q, idx_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           be_q, be_d;
  logic                 err_q, err_d;
  logic                 ready_q, ready_d;
  logic                 rvalid_q, rvalid_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 rerr_q, rerr_d;
  logic                 ram_we_s;
  logic [31:0]          ram_rdata_s;
  logic [3:0]           be_in_s;

`ifdef DM_BYTE_STROBE_EN
  assign be_in_s = req_be;
`else
  assign be_in_s = 4'b1111;
`endif

  dm_word_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (ram_we_s),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .be_i    (be_q),
    .rdata_o (ram_rdata_s)
  );

  // Next-state, request latch, commit and response logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    err_d    = err_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    ram_we_s = 1'b0;
    case (state_q)
      DM_IDLE: begin
        if (req_valid && ready_q) begin
          we_d    = req_we;
          idx_d   = req_addr[ADDR_W+1:2];
          wdata_d = req_wdata;
          be_d    = be_in_s;
          err_d   = dm_addr_err(req_addr, ADDR_W);
          // Counter holds the wait states still to run after this edge.
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = DM_WAIT;
        end else begin
          state_d = DM_IDLE;
        end
      end
      DM_WAIT: begin
        if (cnt_q == 4'd0) begin
          // Commit edge: store lands in storage, load data is captured.
          ram_we_s = we_q && !err_q;
          rvalid_d = 1'b1;
          rerr_d   = err_q;
          rdata_d  = (we_q || err_q) ? 32'h0000_0000 : ram_rdata_s;
          state_d  = DM_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DM_RESP: begin
        if (resp_ready) begin
          rvalid_d = 1'b0;
          state_d  = DM_IDLE;
        end else begin
          state_d = DM_RESP;
        end
      end
      default: begin
        rvalid_d = 1'b0;
        state_d  = DM_IDLE;
      end
    endcase
    ready_d = (state_d == DM_IDLE);
  end

  // State, request latch and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= DM_IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= 32'h0000_0000;
      be_q     <= 4'b0000;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0000_0000;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = rvalid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = rerr_q;

endmodule

// File: tb/tb_dm_resp.sv
// Self-checking bench for dm_resp: a driver issues requests and pushes the
// expected response (computed from a plain word-array model) into a queue;
// an independent monitor pops and compares whenever a response appears.
module tb_dm_resp;
  localparam int AW = 10;
  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_be = 4'hF;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          vedge;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem_m [1024];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dm_resp #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef DM_BYTE_STROBE_EN
    .req_be     (req_be),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Monitor: samples mid-cycle, pops the scoreboard on each response handshake.
  logic        active = 1'b0;
  logic        idle_chk = 1'b0;
  exp_t        cur;
  logic [31:0] h_rdata;
  logic        h_err;

  always @(negedge clk) begin
    #2;
    if (!reset) begin
      active   = 1'b0;
      idle_chk = 1'b0;
    end else begin
      if (idle_chk) begin
        chk("idle_req_ready", {31'b0, req_ready}, 32'd1);
        chk("idle_resp_valid", {31'b0, resp_valid}, 32'd0);
        idle_chk = 1'b0;
      end
      if (resp_valid) begin
        if (!active) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_resp: got rdata %h with empty scoreboard", resp_rdata);
          end else begin
            cur    = sb_q[0];
            active = 1'b1;
            chk("latency_edge", cyc, cur.vedge);
            chk("rdata", resp_rdata, cur.rdata);
            chk("err", {31'b0, resp_err}, {31'b0, cur.err});
            h_rdata = resp_rdata;
            h_err   = resp_err;
          end
        end else begin
          chk("hold_rdata", resp_rdata, h_rdata);
          chk("hold_err", {31'b0, resp_err}, {31'b0, h_err});
          chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        if (resp_ready && active) begin
          void'(sb_q.pop_front());
          active   = 1'b0;
          idle_chk = 1'b1;
        end
      end
    end
  end

  function automatic logic model_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
  endfunction

  task automatic wait_ready(output logic ok);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    ok = (t < 64);
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_ready_timeout: got 0 expected 1 within 64 cycles");
    end
  endtask

  // Issue one request, compute its expected response, then release resp_ready
  // after 'hold' cycles and wait for the monitor to retire it.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int hold);
    int          t;
    exp_t        e;
    logic        ok;
    logic [3:0]  eff_be;
    logic [31:0] w;
    wait_ready(ok);
    if (!ok) return;
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wd;
    req_be     = be;
    resp_ready = 1'b0;
`ifdef DM_BYTE_STROBE_EN
    eff_be = be;
`else
    eff_be = 4'hF;
`endif
    e.err   = model_err(addr);
    e.rdata = (we || e.err) ? 32'h0 : mem_m[addr[AW+1:2]];
    e.vedge = cyc + 2 + WC;
    if (we && !e.err) begin
      w = mem_m[addr[AW+1:2]];
      for (int b = 0; b < 4; b++) begin
        if (eff_be[b]) w[8*b +: 8] = wd[8*b +: 8];
      end
      mem_m[addr[AW+1:2]] = w;
    end
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    repeat (hold) @(negedge clk);
    resp_ready = 1'b1;
    t = 0;
    while (sb_q.size() != 0 && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (t >= 64) begin
      n_cmp++;
      n_bad++;
      $display("FAIL resp_timeout: got no response, expected one within 64 cycles");
      sb_q.delete();
    end
    resp_ready = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) mem_m[i] = 32'h0;
  endtask

  initial begin
    logic        ok;
    logic [31:0] a;
    int          r;
    model_clear();

    // Reset state.
    #12;
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #3;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Store then load the same word.
    do_req(1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 0);
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'hF, 0);
    // Stalled load: response must hold for several cycles.
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'hF, 8);
    // Misaligned / out of range accesses, including a rejected store.
    do_req(1'b0, 32'h0000_0002, 32'h0, 4'hF, 1);
    do_req(1'b0, 32'h0000_1000, 32'h0, 4'hF, 0);
    do_req(1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 4'hF, 0);
    do_req(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'hF, 0);
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'hF, 0);
    // Last word in range.
    do_req(1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 4'hF, 2);
    do_req(1'b0, 32'h0000_0FFC, 32'h0, 4'hF, 0);

`ifdef DM_BYTE_STROBE_EN
    do_req(1'b1, 32'h0000_0030, 32'h1122_3344, 4'hF, 0);
    do_req(1'b1, 32'h0000_0030, 32'hAABB_CCDD, 4'b0101, 0);
    do_req(1'b0, 32'h0000_0030, 32'h0, 4'hF, 0);
    do_req(1'b1, 32'h0000_0030, 32'h5555_5555, 4'b0000, 0);
    do_req(1'b0, 32'h0000_0030, 32'h0, 4'hF, 0);
`endif

    // Reset during the wait states of a store: the store must be lost.
    wait_ready(ok);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h0000_0020;
    req_wdata = 32'hDEAD_BEEF;
    req_be    = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    reset = 1'b0;
    model_clear();
    sb_q.delete();
    #2;
    chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("midrst_resp_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #3;
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    do_req(1'b0, 32'h0000_0020, 32'h0, 4'hF, 0);
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'hF, 0);

    // Randomized traffic over a small word set plus illegal addresses.
    for (int n = 0; n < 48; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6) a = {20'h0, 7'h0, 3'($urandom_range(0, 7)), 2'b00};
      else if (r < 8) a = {20'h0, 8'hFF, 2'($urandom), 2'b00};
      else if (r == 8) a = {20'h0, 10'($urandom), 2'($urandom_range(1, 3))};
      else a = {20'($urandom_range(1, 1048575)), 12'($urandom)};
      do_req(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 4));
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
